cmd_frame_parser: RTL and testbench

Sits between the PC-side uart_controller8bit RX port and the BlueTooth request FIFO input of cmd_handler. It hunts for framed commands in the raw UART byte stream and buffers each payload. It validates length and XOR checksum, and forwards only the payload bytes of good frames over a vld/rdy interface. Bad, oversized or timed-out frames are dropped whole, so the BlueTooth module never sees partial commands.

---
 rtl/cmd_frame_parser_pkg.sv | 19 +
 rtl/cmd_frame_buf.sv | 22 ++
 rtl/cmd_frame_parser.sv | 165 ++++++++++++++++
 tb/tb_cmd_frame_parser.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_parser_pkg.sv
// Shared definitions for the command frame parser: FSM encodings and parameter defaults.
package cmd_frame_parser_pkg;

  localparam logic [2:0] HUNT    = 3'd0;
  localparam logic [2:0] LEN_ST  = 3'd1;
  localparam logic [2:0] PAYLOAD = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;
  localparam logic [2:0] GAP     = 3'd5;

  localparam logic [7:0] SOF_DEFAULT     = 8'hAA;
  localparam int         TIMEOUT_DEFAULT = 50000;

  // States in which the inter-byte timeout is armed.
  function automatic logic is_timed(input logic [2:0] s);
    return (s == LEN_ST) || (s == PAYLOAD) || (s == CHECK);
  endfunction

endpackage

// File: rtl/cmd_frame_buf.sv
// Payload buffer: DEPTH x 8 register array, synchronous write, asynchronous read.
module cmd_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cmd_frame_parser.sv
// Framed-command parser between UART RX and the request FIFO.
// Optional discarded-frame counter enabled by defining CMD_FRAME_ERR_CNT_EN.
//
// state   | meaning
// HUNT    | waiting for SOF, other bytes dropped silently
// LEN_ST  | expecting LEN byte
// PAYLOAD | storing LEN payload bytes, accumulating XOR
// CHECK   | expecting checksum byte
// FLUSH   | forwarding buffered payload on data_o
// GAP     | one idle cycle after each ack so the UART can drop rx_rdy
module cmd_frame_parser
  import cmd_frame_parser_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_ack,
  output logic [7:0]  data_o,
  output logic        data_o_vld,
  input  logic        data_o_rdy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] err_cnt
);

  localparam int             AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state, ret_state;
  logic [7:0]    byte_q;
  logic          byte_vld;
  logic [7:0]    len, chk_acc, wr_ptr, rd_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    rd_data;

  logic recv, timed, sample, tmo_hit, xfer, last_rd, wr_en;

  assign recv    = (state == HUNT) || is_timed(state);
  assign timed   = is_timed(state);
  assign sample  = recv && !byte_vld && rx_rdy;
  // A byte arriving in the same cycle as the timeout wins.
  assign tmo_hit = timed && !byte_vld && !sample && (tmo_cnt == TMO_LAST);
  assign xfer    = (state == FLUSH) && data_o_rdy;
  assign last_rd = (rd_ptr == len - 8'd1);
  assign wr_en   = byte_vld && (state == PAYLOAD);

  cmd_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (byte_q),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  assign data_o_vld = (state == FLUSH);
  assign data_o     = (state == FLUSH) ? rd_data : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      ret_state  <= HUNT;
      byte_q     <= 8'h00;
      byte_vld   <= 1'b0;
      len        <= 8'h00;
      chk_acc    <= 8'h00;
      wr_ptr     <= 8'h00;
      rd_ptr     <= 8'h00;
      rx_ack     <= 1'b0;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      rx_ack     <= sample;
      frame_err  <= 1'b0;
      frame_done <= 1'b0;
      if (sample) begin
        byte_q   <= rx_data;
        byte_vld <= 1'b1;
      end
      if (byte_vld) begin
        byte_vld <= 1'b0;
        state    <= GAP;
        case (state)
          HUNT: ret_state <= (byte_q == SOF_BYTE) ? LEN_ST : HUNT;
          LEN_ST: begin
            if (byte_q == 8'h00 || byte_q > MAX_LEN_B) begin
              frame_err <= 1'b1;
              ret_state <= HUNT;
            end else begin
              len       <= byte_q;
              chk_acc   <= byte_q;
              wr_ptr    <= 8'h00;
              ret_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            chk_acc <= chk_acc ^ byte_q;
            if (wr_ptr == len - 8'd1) begin
              ret_state <= CHECK;
            end else begin
              wr_ptr    <= wr_ptr + 8'd1;
              ret_state <= PAYLOAD;
            end
          end
          CHECK: begin
            if (byte_q == chk_acc) begin
              rd_ptr    <= 8'h00;
              ret_state <= FLUSH;
            end else begin
              frame_err <= 1'b1;
              ret_state <= HUNT;
            end
          end
          default: ret_state <= HUNT;
        endcase
      end else if (state == GAP) begin
        state <= ret_state;
      end else if (tmo_hit) begin
        frame_err <= 1'b1;
        state     <= HUNT;
      end else if (xfer) begin
        if (last_rd) begin
          frame_done <= 1'b1;
          state      <= HUNT;
        end else begin
          rd_ptr <= rd_ptr + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (sample || !timed) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

`ifdef CMD_FRAME_ERR_CNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 16'h0000;
    end else if (frame_err && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Self-checking bench for cmd_frame_parser: frame table, timeout, backpressure and reset cases.
module tb_cmd_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        rx_ack;
  logic [7:0]  data_o;
  logic        data_o_vld;
  logic        data_o_rdy;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] err_cnt;

  cmd_frame_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_ack     (rx_ack),
    .data_o     (data_o),
    .data_o_vld (data_o_vld),
    .data_o_rdy (data_o_rdy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] b;     // transmitted bytes, first byte in the most significant used position
    int           n;
    logic [127:0] e;     // expected payload bytes, same ordering
    int           ne;
    bit           done;
    bit           err;
  } rec_t;

  localparam int NREC = 8;
  rec_t  tbl   [NREC];
  string names [NREC];

  logic [7:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int exp_ec    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_err_cnt();
`ifdef CMD_FRAME_ERR_CNT_EN
    return 32'(exp_ec);
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (data_o_vld && data_o_rdy) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_data: got %0h expected no output", data_o);
        end else begin
          chk("data_o", 32'(data_o), 32'(sb.pop_front()));
        end
      end
      if (frame_done) done_seen++;
      if (frame_err)  err_seen++;
      if (frame_done || frame_err)
        chk("done_err_exclusive", 32'(frame_done & frame_err), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rx_ack && w < 100);
    if (!rx_ack) chk("ack_timeout", 32'(w), 32'd0);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
  endtask

  task automatic wait_end(input int d0, input int e0, input int bound);
    int w;
    w = 0;
    while (done_seen == d0 && err_seen == e0 && w < bound) begin
      @(negedge clk); #1;
      w++;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic run_rec(input int r);
    int d0, e0;
    for (int k = 0; k < tbl[r].ne; k++) sb.push_back(tbl[r].e[8*(tbl[r].ne-1-k) +: 8]);
    d0 = done_seen;
    e0 = err_seen;
    for (int k = 0; k < tbl[r].n; k++) send_byte(tbl[r].b[8*(tbl[r].n-1-k) +: 8]);
    wait_end(d0, e0, 400);
    if (tbl[r].err) exp_ec++;
    chk({names[r], "_done"},    32'(done_seen - d0), 32'(tbl[r].done));
    chk({names[r], "_err"},     32'(err_seen - e0),  32'(tbl[r].err));
    chk({names[r], "_sb_left"}, 32'(sb.size()),      32'd0);
    chk({names[r], "_err_cnt"}, 32'(err_cnt),        exp_err_cnt());
  endtask

  initial begin
    int d0, e0, w;

    names[0] = "good3";     tbl[0] = '{b: 160'h AA0311223303, n: 6, e: 128'h112233, ne: 3, done: 1, err: 0};
    names[1] = "garbage";   tbl[1] = '{b: 160'h 00FFAA017E7F, n: 6, e: 128'h7E,     ne: 1, done: 1, err: 0};
    names[2] = "bad_chk";   tbl[2] = '{b: 160'h AA02556630,   n: 5, e: 128'h0,      ne: 0, done: 0, err: 1};
    names[3] = "len_zero";  tbl[3] = '{b: 160'h AA00,         n: 2, e: 128'h0,      ne: 0, done: 0, err: 1};
    names[4] = "len_17";    tbl[4] = '{b: 160'h AA11,         n: 2, e: 128'h0,      ne: 0, done: 0, err: 1};
    names[5] = "good1";     tbl[5] = '{b: 160'h AA014243,     n: 4, e: 128'h42,     ne: 1, done: 1, err: 0};
    names[6] = "sof_data";  tbl[6] = '{b: 160'h AA02AA05AD,   n: 5, e: 128'hAA05,   ne: 2, done: 1, err: 0};
    names[7] = "max_len";
    tbl[7] = '{b: 160'({8'hAA, 8'h10, 128'h000102030405060708090A0B0C0D0E0F, 8'h10}), n: 19,
               e: 128'h000102030405060708090A0B0C0D0E0F, ne: 16, done: 1, err: 0};

    rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; data_o_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_ack",     32'(rx_ack),     32'd0);
    chk("rst_data_o",     32'(data_o),     32'd0);
    chk("rst_data_o_vld", 32'(data_o_vld), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err",  32'(frame_err),  32'd0);
    chk("rst_err_cnt",    32'(err_cnt),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < NREC; r++) run_rec(r);

    // Inter-byte timeout in the middle of a payload.
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10);
    e0 = err_seen;
    w = 0;
    while (err_seen == e0 && w < 60000) begin
      @(negedge clk); #1;
      w++;
    end
    exp_ec++;
    chk("timeout_err",    32'(err_seen - e0), 32'd1);
    chk("timeout_window", 32'(w >= 49990 && w <= 50010), 32'd1);
    repeat (3) @(negedge clk);
    chk("timeout_err_cnt", 32'(err_cnt), exp_err_cnt());
    run_rec(0);

    // Backpressure during flush with a byte pending at the UART.
    @(posedge clk); #1;
    data_o_rdy = 1'b0;
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    d0 = done_seen; e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    rx_data = 8'h00;
    rx_rdy  = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!data_o_vld && w < 50);
    chk("bp_vld", 32'(data_o_vld), 32'd1);
    @(posedge clk); #1;
    data_o_rdy = 1'b1;
    @(posedge clk); #1;
    data_o_rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_data_hold", 32'(data_o), 32'h22);
      chk("bp_no_ack",    32'(rx_ack), 32'd0);
    end
    @(posedge clk); #1;
    data_o_rdy = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rx_ack && w < 100);
    chk("bp_pending_ack", 32'(rx_ack), 32'd1);
    @(posedge clk); #1;
    rx_rdy = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_done",    32'(done_seen - d0), 32'd1);
    chk("bp_err",     32'(err_seen - e0),  32'd0);
    chk("bp_sb_left", 32'(sb.size()),      32'd0);

    // Reset asserted in the middle of a flush.
    @(posedge clk); #1;
    data_o_rdy = 1'b0;
    e0 = err_seen;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!data_o_vld && w < 50);
    chk("mid_flush_vld", 32'(data_o_vld), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_rx_ack",     32'(rx_ack),     32'd0);
    chk("mr_data_o",     32'(data_o),     32'd0);
    chk("mr_data_o_vld", 32'(data_o_vld), 32'd0);
    chk("mr_frame_done", 32'(frame_done), 32'd0);
    chk("mr_frame_err",  32'(frame_err),  32'd0);
    chk("mr_err_cnt",    32'(err_cnt),    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_o_rdy = 1'b1;
    exp_ec = 0;
    repeat (5) @(negedge clk);
    chk("mr_idle_vld", 32'(data_o_vld),      32'd0);
    chk("mr_no_err",   32'(err_seen - e0),   32'd0);
    run_rec(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
